// File: rtl/wfifo_drain_pkg.sv
// wfifo_drain_pkg: state encoding and width helper shared by the drain controller files
package wfifo_drain_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WAIT  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    function automatic int cw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/wfifo_drain_mem.sv
// wfifo_drain_mem: FIFO storage, pointers, fill count and push/pop qualification
module wfifo_drain_mem
    import wfifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    winc,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cw_of(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop_ok;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign pop_ok = pop && !empty && !flush;
    // a full FIFO still takes a word when the head leaves in the same cycle
    assign push   = winc && !flush && (!full || pop_ok);
    assign drop   = winc && !flush && full && !pop_ok;
    assign rdata  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/wfifo_drain_ctrl.sv
// wfifo_drain_ctrl: buffers register-block write strobes and drains them on fill threshold or age timeout
module wfifo_drain_ctrl
    import wfifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     RegClk,
    input  logic                     RegReset_n,
    input  logic                     wfifo_winc,
    input  logic [DATA_WIDTH-1:0]    wfifo_wdata,
    input  logic                     enable,
    input  logic [$clog2(DEPTH):0]   threshold,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     busy
);
    localparam int CW = cw_of(DEPTH);
    state_t state, state_nx;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic [CW-1:0] thr_eff;
    logic drop, aged, hit, hold;
    assign thr_eff = threshold == '0 ? CW'(1) : threshold > CW'(DEPTH) ? CW'(DEPTH) : threshold;
    assign hit     = count >= thr_eff;
    assign aged    = timeout != '0 && timer == timeout;
    assign hold    = out_valid && !out_ready;
    wfifo_drain_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (RegClk),
        .rst_n (RegReset_n),
        .flush (flush),
        .winc  (wfifo_winc),
        .wdata (wfifo_wdata),
        .pop   (out_valid && out_ready),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );
    always_ff @(posedge RegClk)
        state <= (!RegReset_n || flush) ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (enable && hit) ? DRAIN : count != '0 ? WAIT : IDLE;
            WAIT:    state_nx = count == '0 ? IDLE : (enable && (hit || aged)) ? DRAIN : WAIT;
            // a presented beat is never withdrawn when enable drops
            DRAIN:   state_nx = count == '0 ? IDLE : (!enable && !hold) ? WAIT : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        out_valid = state == DRAIN && !empty && !flush;
        busy      = state != IDLE;
    end
    // outside WAIT the timer sits at zero so WAIT always starts from a cleared age
    always_ff @(posedge RegClk)
        if (!RegReset_n || flush || state != WAIT) timer <= '0;
        else if (enable && timer != '1) timer <= timer + 1'b1;
    always_ff @(posedge RegClk)
        if (!RegReset_n) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
endmodule

// File: tb/tb_wfifo_drain_ctrl.sv
// tb_wfifo_drain_ctrl: directed checks of threshold/timeout drain, overflow, backpressure, flush and reset
module tb_wfifo_drain_ctrl;
    logic       RegClk = 1'b0;
    logic       RegReset_n = 1'b0;
    logic       wfifo_winc = 1'b0;
    logic [7:0] wfifo_wdata = '0;
    logic       enable = 1'b0;
    logic [3:0] threshold = '0;
    logic [7:0] timeout = '0;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, empty, full, overflow, busy;
    logic [7:0] out_data;
    logic [3:0] count;
    int total = 0;
    int bad = 0;

    wfifo_drain_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .TIMEOUT_WIDTH(8)) dut (
        .RegClk(RegClk), .RegReset_n(RegReset_n), .wfifo_winc(wfifo_winc), .wfifo_wdata(wfifo_wdata),
        .enable(enable), .threshold(threshold), .timeout(timeout), .flush(flush), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .busy(busy)
    );

    always #5 RegClk = ~RegClk;

    task automatic tick();
        @(posedge RegClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset("rst");
        RegReset_n = 1'b1;

        // threshold=1 path: push in cycle 0, count=1 in cycle 1, valid in cycle 2
        enable = 1'b1; threshold = 4'd0; out_ready = 1'b1;
        wfifo_winc = 1'b1; wfifo_wdata = 8'h80;
        tick();
        wfifo_winc = 1'b0;
        chk("thr1_cnt", count, 1);
        chk("thr1_v0", out_valid, 0);
        tick();
        chk("thr1_v1", out_valid, 1);
        chk("thr1_d", out_data, 8'h80);
        tick();
        chk("thr1_cnt0", count, 0);
        tick();
        chk("thr1_idle", busy, 0);

        // threshold drain of four words
        threshold = 4'd4; timeout = 8'd0;
        for (int i = 0; i < 4; i++) begin
            wfifo_winc = 1'b1; wfifo_wdata = 8'h11 + 8'(i);
            tick();
        end
        wfifo_winc = 1'b0;
        chk("thr_cnt4", count, 4);
        chk("thr_wait", out_valid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("thr_v", out_valid, 1);
            chk("thr_d", out_data, 8'h11 + i);
            tick();
        end
        chk("thr_end_v", out_valid, 0);
        chk("thr_end_cnt", count, 0);
        tick();
        chk("thr_idle", busy, 0);
        chk("thr_empty", empty, 1);

        // timeout drain: WAIT entered in cycle w, valid in w+6
        threshold = 4'd8; timeout = 8'd5;
        wfifo_winc = 1'b1; wfifo_wdata = 8'hA5;
        tick();
        wfifo_winc = 1'b0;
        tick();
        chk("to_busy", busy, 1);
        chk("to_v_w", out_valid, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("to_v_w5", out_valid, 0);
        tick();
        chk("to_v_w6", out_valid, 1);
        chk("to_d", out_data, 8'hA5);
        tick();
        tick();
        chk("to_idle", busy, 0);

        // overflow: nine pushes into eight entries while draining is held off
        enable = 1'b0; out_ready = 1'b0; timeout = 8'd0;
        for (int i = 0; i < 9; i++) begin
            wfifo_winc = 1'b1; wfifo_wdata = 8'h30 + 8'(i);
            tick();
        end
        chk("ovf_cnt", count, 8);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        wfifo_wdata = 8'h39; clr_ovf = 1'b1;
        tick();
        chk("ovf_setwins", overflow, 1);
        wfifo_winc = 1'b0;
        tick();
        chk("ovf_clr", overflow, 0);
        clr_ovf = 1'b0; enable = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("ovf_v", out_valid, 1);
            chk("ovf_d", out_data, 8'h30 + i);
            tick();
        end
        chk("ovf_9th_absent", out_valid, 0);
        tick();
        chk("ovf_idle", busy, 0);

        // backpressure with pushes during the stall
        threshold = 4'd2; out_ready = 1'b0;
        wfifo_winc = 1'b1; wfifo_wdata = 8'h50;
        tick();
        wfifo_wdata = 8'h51;
        tick();
        wfifo_winc = 1'b0;
        tick();
        out_ready = 1'b1;
        chk("bp_v0", out_valid, 1);
        chk("bp_d0", out_data, 8'h50);
        tick();
        out_ready = 1'b0; wfifo_winc = 1'b1; wfifo_wdata = 8'h52;
        chk("bp_d1", out_data, 8'h51);
        chk("bp_cnt1", count, 1);
        tick();
        wfifo_wdata = 8'h53;
        chk("bp_stall_v", out_valid, 1);
        chk("bp_stall_d", out_data, 8'h51);
        chk("bp_cnt2", count, 2);
        tick();
        out_ready = 1'b1; wfifo_wdata = 8'h54;
        chk("bp_stall2_d", out_data, 8'h51);
        chk("bp_cnt3", count, 3);
        tick();
        wfifo_winc = 1'b0;
        chk("bp_pushpop_cnt", count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_v", out_valid, 1);
            chk("bp_d", out_data, 8'h52 + i);
            tick();
        end
        chk("bp_end_cnt", count, 0);
        chk("bp_end_v", out_valid, 0);
        tick();

        // flush mid-drain with a concurrent push
        out_ready = 1'b0;
        wfifo_winc = 1'b1; wfifo_wdata = 8'h60;
        tick();
        wfifo_wdata = 8'h61;
        tick();
        wfifo_winc = 1'b0;
        tick();
        chk("fl_pre_v", out_valid, 1);
        flush = 1'b1; wfifo_winc = 1'b1; wfifo_wdata = 8'h62;
        #1;
        chk("fl_v_now", out_valid, 0);
        tick();
        flush = 1'b0; wfifo_winc = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_v", out_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_ovf", overflow, 0);
        tick();
        chk("fl_discard", count, 0);

        // reset mid-drain
        wfifo_winc = 1'b1; wfifo_wdata = 8'h70;
        tick();
        wfifo_wdata = 8'h71;
        tick();
        wfifo_winc = 1'b0;
        tick();
        chk("rm_pre_v", out_valid, 1);
        RegReset_n = 1'b0;
        tick();
        RegReset_n = 1'b1;
        chk_reset("rm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wfifo_drain_ctrl.md
# wfifo_drain_ctrl

Buffers and sequences the write-FIFO strobe stream (`wfifo_winc_*` / `wfifo_*` data) produced by a generated register block. Each strobe pushes one word into an internal FIFO. A drain FSM then releases the words to a downstream consumer over valid/ready, starting either on a fill threshold or on an age timeout. Software controls come from register fields, and status returns through read-only register fields.

## Interface
- `DATA_WIDTH`, 8, width of the pushed word
- `DEPTH`, 8, FIFO entries; power of two, ≥2; `CW = $clog2(DEPTH)+1`
- `TIMEOUT_WIDTH`, 8, width of the timeout field and age timer
- `RegClk  in  1  block clock`
- `RegReset_n  in  1  reset; synchronous, active-low`
- `wfifo_winc  in  1  push strobe, one word per high cycle`
- `wfifo_wdata  in  DATA_WIDTH  push data, valid with wfifo_winc`
- `enable  in  1  drain enable`
- `threshold  in  CW  drain-start fill level; 0 behaves as 1; values >DEPTH behave as DEPTH`
- `timeout  in  TIMEOUT_WIDTH  age-out cycles in WAIT; 0 disables`
- `flush  in  1  discard all contents and abort any drain`
- `clr_ovf  in  1  clear the overflow flag`
- `out_valid  out  1  downstream word valid`
- `out_data  out  DATA_WIDTH  downstream word (head of FIFO)`
- `out_ready  in  1  downstream accept`
- `count  out  CW  current fill level`
- `empty` / `full`  out  1 each  fill status
- `overflow  out  1  sticky: a push was dropped`
- `busy  out  1  state != IDLE`

## Operation
- Push: a strobe is accepted if `!full`, or if it is `full` with a pop in the same cycle. Otherwise the word is dropped and `overflow` is set.
- Pop: occurs when `out_valid && out_ready`. The read pointer advances, and `out_data` shows the next entry the following cycle.
- `count` update: +1 on push only, -1 on pop only, unchanged on push+pop. Pointers wrap modulo `DEPTH`.
- FSM states, evaluated on registered `count`:
  - IDLE (`count==0`):
    - if `count>0`, go to WAIT.
    - if `enable` and `count>=thr_eff`, go to DRAIN directly.
  - WAIT:
    - age timer clears on entry and increments each cycle while `enable`, saturating. It holds while `!enable`.
    - go to DRAIN if `enable` and (`count>=thr_eff`, or `timeout!=0` and timer==`timeout`).
  - DRAIN:
    - `out_valid = !empty`.
    - when `count` reaches 0, go to IDLE.
    - if `enable` drops, the current beat stays presented until accepted (valid never retracts), then go to WAIT.
- `overflow`: set has priority over `clr_ovf` in the same cycle. `flush` does not change it.
- `flush`: next cycle has pointers=0, `count=0`, state IDLE, timer 0. A push in the flush cycle is discarded and does not set `overflow`. `out_valid` drops immediately; this is the only permitted valid retraction.

## Timing
- Reset values: `out_valid=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `busy=0`, `out_data=0`. Memory contents are not reset.
- Threshold path: with `enable=1` and `threshold=1`, `wfifo_winc` in cycle 0 gives `count=1` in cycle 1, and `out_valid=1` in cycle 2.
- Timeout path: entry to WAIT in cycle w with `timeout=N` gives `out_valid` in cycle w+N+1, provided the threshold is not hit first.
- Throughput in DRAIN: one word per cycle while `out_ready=1`. There is no bubble between beats.
- Reset mid-drain: all state returns to reset values on the next edge; the handshake is abandoned.

## Structure
- Shared package `wfifo_drain_pkg` holds:
  - state encoding localparams (IDLE=0, WAIT=1, DRAIN=2)
  - the `CW` width helper
- Sub-module `wfifo_drain_mem`: storage array, read/write pointers, count, `full`/`empty`, and the push/pop qualification.
- The top module holds the FSM, the age timer, `overflow`, and the output muxing.

## Test plan
- Threshold drain: `DEPTH=8`, `threshold=4`, `timeout=0`. Push 0x11..0x14 on consecutive cycles → `out_valid` rises 2 cycles after the 4th push, data 0x11..0x14 in order with `out_ready=1`, then IDLE with `empty=1`.
- Timeout drain: `threshold=8`, `timeout=5`. Push 0xA5 once → `out_valid` 6 cycles after WAIT entry, data 0xA5.
- Overflow and simultaneous ops:
  - 9 pushes with `out_ready=0` and `enable=0` → `count=8`, `full=1`, `overflow=1`, 9th word absent from the output.
  - `clr_ovf` together with a new drop → `overflow` stays 1.
- Backpressure: in DRAIN, toggle `out_ready` 1,0,0,1, push in the stall cycles → `out_valid`/`out_data` stable while stalled, no loss, no duplicates, `count` correct on push+pop cycles.
- Flush mid-drain with a concurrent push: `count=0`, `out_valid=0` next cycle, the pushed word is discarded, `overflow` is unchanged.
- Reset mid-drain: `RegReset_n=0` for one cycle → all outputs at reset values on the following cycle.
